audio_gain_ramp: RTL



---
 rtl/audio_gain_ramp.sv | 139 +++++++++++++
 1 files changed

// File: rtl/audio_gain_ramp.sv
// Multi-channel audio gain stage with per-frame gain ramping and saturation.
// One shared multiplier processes one channel per clock between valid/ready handshakes.
module audio_gain_ramp #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 2,
    parameter int GAIN_W    = 8,
    parameter int FRAC      = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [GAIN_W-1:0]         gain_target,
    input  logic                      mute,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       clip_flags,
    input  logic                      clip_clear,
    output logic [GAIN_W-1:0]         cur_gain
);

    localparam int PW   = WIDTH + GAIN_W + 1;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                    state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [CHANNELS*WIDTH-1:0] frame_q;
    logic [CHANNELS*WIDTH-1:0] out_data_q;
    logic [GAIN_W-1:0]         frame_gain_q;
    logic [GAIN_W-1:0]         cur_gain_q;
    logic [CH_W-1:0]           ch_q;
    logic [CHANNELS-1:0]       clip_q;
    logic [CHANNELS-1:0]       clip_d;
    logic [WIDTH-1:0]          sample;
    logic [WIDTH:0]            res;

    // Move cur toward tgt by at most RAMP_STEP, landing exactly on tgt.
    function automatic logic [GAIN_W-1:0] ramp_gain(input logic [GAIN_W-1:0] cur,
                                                    input logic [GAIN_W-1:0] tgt);
        logic [GAIN_W-1:0] step;
        step = GAIN_W'(RAMP_STEP);
        if (tgt >= cur) begin
            if ((tgt - cur) <= step) return tgt;
            return cur + step;
        end
        if ((cur - tgt) <= step) return tgt;
        return cur - step;
    endfunction

    // Returns {clipped, value}; the shift floors because it is arithmetic.
    function automatic logic [WIDTH:0] scale_sat(input logic signed [WIDTH-1:0] s,
                                                 input logic [GAIN_W-1:0]       g);
        logic signed [PW-1:0] sx;
        logic signed [PW-1:0] gx;
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] r;
        sx = {{(PW-WIDTH){s[WIDTH-1]}}, s};
        gx = {{(PW-GAIN_W){1'b0}}, g};
        p  = sx * gx;
        r  = p >>> FRAC;
        if (!r[PW-1] && (|r[PW-2:WIDTH-1]))
            return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        if (r[PW-1] && !(&r[PW-2:WIDTH-1]))
            return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        return {1'b0, r[WIDTH-1:0]};
    endfunction

    assign sample = frame_q[ch_q*WIDTH +: WIDTH];
    assign res    = scale_sat(sample, frame_gain_q);

    always_comb begin
        clip_d = clip_q;
        if (clip_clear) clip_d = '0;
        if (state_q == CALC && res[WIDTH]) clip_d[ch_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            frame_q      <= '0;
            out_data_q   <= '0;
            frame_gain_q <= '0;
            cur_gain_q   <= '0;
            ch_q         <= '0;
            clip_q       <= '0;
        end else begin
            clip_q <= clip_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        frame_q      <= in_data;
                        frame_gain_q <= cur_gain_q;
                        cur_gain_q   <= ramp_gain(cur_gain_q, mute ? '0 : gain_target);
                        ch_q         <= '0;
                        in_ready_q   <= 1'b0;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    out_data_q[ch_q*WIDTH +: WIDTH] <= res[WIDTH-1:0];
                    if (ch_q == LAST_CH) begin
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign clip_flags = clip_q;
    assign cur_gain   = cur_gain_q;

endmodule
